serial_arith_seq: RTL and testbench

- Bit-serial sequencer for the one-bit reversible arithmetic slice.
- Accepts a WIDTH-bit operation request and latches the operands.
- Drives the external slice LSB-first, one bit per clock, holding the select lines and gin constant.
- Chains the carry, reassembles the result, and returns it with carry-out and signed-overflow over a valid/ready response handshake. Lets one slice replace a WIDTH-slice ripple array.

---
 rtl/arith_seq_pkg.sv | 15 +
 rtl/serial_shreg.sv | 40 ++++
 rtl/serial_arith_seq.sv | 179 +++++++++++++++++
 tb/tb_serial_arith_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_seq_pkg.sv
// Shared types and defaults for the bit-serial arithmetic sequencer.
// Contents: FSM state encoding, default operand width and bit-counter width.
// Imported by serial_arith_seq and serial_shreg.
package arith_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 5;

endpackage

// File: rtl/serial_shreg.sv
// WIDTH-bit register with parallel load and right shift; ser_in enters at the MSB.
// Ports: clk/rst (async active-high), load (priority), shift, load_val, ser_in, q.
// Latency: q updates on the edge after load/shift; holds otherwise.
module serial_shreg
  import arith_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift) begin
      q_d = {ser_in, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_arith_seq.sv
// Bit-serial sequencer driving one external arithmetic slice LSB-first, one bit per clock.
// Ports: req_* valid/ready request in, slice_* to/from the slice, rsp_* valid/ready response out, busy.
// Latency: rsp_valid rises WIDTH edges after the accepting edge; req_ready is low in RUN and DONE.
module serial_arith_seq
  import arith_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_sel,
  input  logic             req_cin,
  input  logic             req_gin,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_s0,
  output logic             slice_s1,
  output logic             slice_s2,
  output logic             slice_gin,
  input  logic             slice_out,
  input  logic             slice_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic [2:0]       sel_q, sel_d;
  logic             gin_q, gin_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             op_load;
  logic             op_shift;

  // Operand registers only expose their LSB to the slice; the rest of the
  // parallel view is intentionally left unused.
  logic [WIDTH-1:0] a_sr_unused;
  logic [WIDTH-1:0] b_sr_unused;
  logic [WIDTH-1:0] res_sr;

  serial_shreg #(.WIDTH(WIDTH)) u_a_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (op_load),
    .shift    (op_shift),
    .load_val (req_a),
    .ser_in   (1'b0),
    .q        (a_sr_unused)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_b_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (op_load),
    .shift    (op_shift),
    .load_val (req_b),
    .ser_in   (1'b0),
    .q        (b_sr_unused)
  );

  // After WIDTH shifts the first result bit has walked down to bit 0.
  serial_shreg #(.WIDTH(WIDTH)) u_res_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (op_load),
    .shift    (op_shift),
    .load_val ('0),
    .ser_in   (slice_out),
    .q        (res_sr)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cmsb_d    = cmsb_q;
    sel_d     = sel_q;
    gin_d     = gin_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    op_load   = 1'b0;
    op_shift  = 1'b0;
    slice_a   = 1'b0;
    slice_b   = 1'b0;
    slice_cin = 1'b0;
    slice_s0  = 1'b0;
    slice_s1  = 1'b0;
    slice_s2  = 1'b0;
    slice_gin = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_load = 1'b1;
          sel_d   = req_sel;
          gin_d   = req_gin;
          carry_d = req_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        slice_a   = a_sr_unused[0];
        slice_b   = b_sr_unused[0];
        slice_cin = carry_q;
        slice_s0  = sel_q[0];
        slice_s1  = sel_q[1];
        slice_s2  = sel_q[2];
        slice_gin = gin_q;
        op_shift  = 1'b1;
        carry_d   = slice_cout;
        cnt_d     = cnt_q + CNT_W'(1);
        // The carry out of bit WIDTH-2 is the carry into the MSB.
        if (cnt_q == CNT_PRE) begin
          cmsb_d = slice_cout;
        end
        if (cnt_q == CNT_LAST) begin
          cout_d  = slice_cout;
          ovf_d   = cmsb_q ^ slice_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      sel_q   <= 3'b000;
      gin_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      sel_q   <= sel_d;
      gin_q   <= gin_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign rsp_result = res_sr;
  assign rsp_cout   = cout_q;
  assign rsp_ovf    = ovf_q;

endmodule

// File: tb/tb_serial_arith_seq.sv
module tb_serial_arith_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_sel;
  logic        req_cin;
  logic        req_gin;
  logic        slice_a, slice_b, slice_cin;
  logic        slice_s0, slice_s1, slice_s2, slice_gin;
  logic        slice_out, slice_cout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_cout;
  logic        rsp_ovf;
  logic        busy;

  int total = 0;
  int bad   = 0;

  serial_arith_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .req_cin    (req_cin),
    .req_gin    (req_gin),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_s0   (slice_s0),
    .slice_s1   (slice_s1),
    .slice_s2   (slice_s2),
    .slice_gin  (slice_gin),
    .slice_out  (slice_out),
    .slice_cout (slice_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy)
  );

  // Full-adder slice model; select lines are ignored.
  assign slice_out  = slice_a ^ slice_b ^ slice_cin;
  assign slice_cout = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] slice_bus();
    return {slice_a, slice_b, slice_cin, slice_s2, slice_s1, slice_s0, slice_gin};
  endfunction

  // Runs one request to completion and reports what was observed.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                       input logic cin, input logic gin,
                       output logic [31:0] res, output logic co, output logic ov,
                       output int lat, output logic [31:0] sa,
                       output bit pt_ok, output bit done_zero);
    req_a = a; req_b = b; req_sel = sel; req_cin = cin; req_gin = gin;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; sa = '0; pt_ok = 1'b1;
    while (!rsp_valid && lat < 100) begin
      if (busy) begin
        if (lat < 32) sa[lat] = slice_a;
        if ({slice_s2, slice_s1, slice_s0, slice_gin} !== {sel, gin}) pt_ok = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    res = rsp_result; co = rsp_cout; ov = rsp_ovf;
    done_zero = (slice_bus() === 7'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_a = 32'h5; req_b = 32'h3;
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (slice_bus() !== 7'd0) begin bad++; $display("FAIL reset_slice got=%b exp=0", slice_bus()); end
    total++; if ({rsp_result, rsp_cout, rsp_ovf} !== 34'd0) begin bad++;
      $display("FAIL reset_rsp got=%h/%b/%b exp=0/0/0", rsp_result, rsp_cout, rsp_ovf); end
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_add();
    logic [31:0] res, sa; logic co, ov; int lat; bit pt, dz;
    do_op(32'h5, 32'h3, 3'b000, 1'b0, 1'b0, res, co, ov, lat, sa, pt, dz);
    total++; if (res !== 32'h8) begin bad++; $display("FAIL add_result got=%h exp=00000008", res); end
    total++; if ({co, ov} !== 2'b00) begin bad++; $display("FAIL add_flags got=%b%b exp=00", co, ov); end
    total++; if (lat !== 32) begin bad++; $display("FAIL add_latency got=%0d exp=32", lat); end
    total++; if (sa !== 32'h5) begin bad++; $display("FAIL add_slice_a_seq got=%h exp=00000005", sa); end
    total++; if (dz !== 1'b1) begin bad++; $display("FAIL add_done_slice_zero got=%b exp=1", dz); end
  endtask

  task automatic test_carry();
    logic [31:0] va [3] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0};
    logic [31:0] vb [3] = '{32'h1, 32'h1, 32'h0};
    logic        vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] er [3] = '{32'h0, 32'h80000000, 32'h1};
    logic        eco[3] = '{1'b1, 1'b0, 1'b0};
    logic        eov[3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] res, sa; logic co, ov; int lat; bit pt, dz;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], 3'b000, vc[i], 1'b0, res, co, ov, lat, sa, pt, dz);
      total++; if (res !== er[i]) begin bad++; $display("FAIL carry_result[%0d] got=%h exp=%h", i, res, er[i]); end
      total++; if (co !== eco[i]) begin bad++; $display("FAIL carry_cout[%0d] got=%b exp=%b", i, co, eco[i]); end
      total++; if (ov !== eov[i]) begin bad++; $display("FAIL carry_ovf[%0d] got=%b exp=%b", i, ov, eov[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res, sa; logic co, ov; int lat; bit pt, dz;
    int n;
    req_a = 32'h10; req_b = 32'h20; req_sel = 3'b000; req_cin = 1'b0; req_gin = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    total++; if (n !== 32) begin bad++; $display("FAIL bp_latency got=%0d exp=32", n); end
    for (int i = 0; i < 5; i++) begin
      req_valid = i[0] ? 1'b0 : 1'b1;
      req_a = 32'hDEAD0000 + 32'(i);
      @(posedge clk); #1;
      total++;
      if ({rsp_valid, req_ready, rsp_result} !== {1'b1, 1'b0, 32'h30}) begin bad++;
        $display("FAIL bp_hold[%0d] got vld=%b rdy=%b res=%h exp vld=1 rdy=0 res=00000030",
                 i, rsp_valid, req_ready, rsp_result); end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++; if ({busy, rsp_valid, req_ready} !== 3'b001) begin bad++;
      $display("FAIL bp_release got busy=%b vld=%b rdy=%b exp 0/0/1", busy, rsp_valid, req_ready); end
    do_op(32'h1, 32'h1, 3'b000, 1'b0, 1'b0, res, co, ov, lat, sa, pt, dz);
    total++; if (res !== 32'h2 || lat !== 32) begin bad++;
      $display("FAIL bp_next_op got res=%h lat=%0d exp res=00000002 lat=32", res, lat); end
  endtask

  task automatic test_abort();
    logic [31:0] res, sa; logic co, ov; int lat; bit pt, dz;
    bit seen;
    req_a = 32'h0000FFFF; req_b = 32'h1; req_sel = 3'b000; req_cin = 1'b0; req_gin = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_running got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    total++; if ({busy, rsp_valid, req_ready} !== 3'b001 || slice_bus() !== 7'd0) begin bad++;
      $display("FAIL abort_immediate got busy=%b vld=%b rdy=%b slice=%b exp 0/0/1/0",
               busy, rsp_valid, req_ready, slice_bus()); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (37) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_rsp got=%b exp=0", seen); end
    do_op(32'h12345678, 32'h11111111, 3'b000, 1'b0, 1'b0, res, co, ov, lat, sa, pt, dz);
    total++; if (res !== 32'h23456789) begin bad++; $display("FAIL abort_next_op got=%h exp=23456789", res); end
  endtask

  task automatic test_passthru();
    logic [31:0] res, sa; logic co, ov; int lat; bit pt, dz;
    req_sel = 3'b101; req_gin = 1'b1;
    @(posedge clk); #1;
    total++; if (slice_bus() !== 7'd0) begin bad++; $display("FAIL pt_idle_before got=%b exp=0", slice_bus()); end
    do_op(32'h0000000C, 32'h00000004, 3'b101, 1'b0, 1'b1, res, co, ov, lat, sa, pt, dz);
    total++; if (pt !== 1'b1) begin bad++; $display("FAIL pt_run_sel got=%b exp=1", pt); end
    total++; if (dz !== 1'b1) begin bad++; $display("FAIL pt_done_zero got=%b exp=1", dz); end
    total++; if (res !== 32'h10) begin bad++; $display("FAIL pt_result got=%h exp=00000010", res); end
    total++; if (slice_bus() !== 7'd0) begin bad++; $display("FAIL pt_idle_after got=%b exp=0", slice_bus()); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_sel = '0;
    req_cin = 1'b0; req_gin = 1'b0; rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_carry();
    test_backpressure();
    test_abort();
    test_passthru();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
